// File: rtl/vga_timing_sequencer.sv
// VGA raster sequencer: horizontal and vertical phase FSMs (ACTIVE/FRONT/SYNC/BACK)
// driving registered sync levels, display enable, pixel coordinates and line/frame strobes.
module vga_timing_sequencer #(
  parameter int unsigned H_ACTIVE        = 1024,
  parameter int unsigned H_FRONT         = 24,
  parameter int unsigned H_SYNC          = 136,
  parameter int unsigned H_BACK          = 160,
  parameter int unsigned V_ACTIVE        = 768,
  parameter int unsigned V_FRONT         = 3,
  parameter int unsigned V_SYNC          = 6,
  parameter int unsigned V_BACK          = 29,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned COUNTER_SIZE    = 11
) (
  input  logic                    control_clock,
  input  logic                    reset_n,
  input  logic                    enable,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic                    display_enable,
  output logic [COUNTER_SIZE-1:0] pixel_x,
  output logic [COUNTER_SIZE-1:0] pixel_y,
  output logic                    line_start,
  output logic                    frame_start
);

  localparam int unsigned CW = COUNTER_SIZE;

  localparam logic [CW-1:0] H_ACTIVE_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_FRONT_LAST  = CW'(H_FRONT - 1);
  localparam logic [CW-1:0] H_SYNC_LAST   = CW'(H_SYNC - 1);
  localparam logic [CW-1:0] H_BACK_LAST   = CW'(H_BACK - 1);
  localparam logic [CW-1:0] V_ACTIVE_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_FRONT_LAST  = CW'(V_FRONT - 1);
  localparam logic [CW-1:0] V_SYNC_LAST   = CW'(V_SYNC - 1);
  localparam logic [CW-1:0] V_BACK_LAST   = CW'(V_BACK - 1);

  localparam logic SYNC_ON  = ~SYNC_ACTIVE_LOW;
  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  phase_e          h_state, h_state_nxt, v_state, v_state_nxt;
  logic [CW-1:0]   h_cnt, h_cnt_nxt, v_cnt, v_cnt_nxt;
  logic [CW-1:0]   h_last, v_last;
  logic            end_of_line, end_of_frame;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_ACTIVE: next_phase = PH_FRONT;
      PH_FRONT:  next_phase = PH_SYNC;
      PH_SYNC:   next_phase = PH_BACK;
      default:   next_phase = PH_ACTIVE;
    endcase
  endfunction

  // Last counter value of the current phase for each axis.
  always_comb begin
    case (h_state)
      PH_ACTIVE: h_last = H_ACTIVE_LAST;
      PH_FRONT:  h_last = H_FRONT_LAST;
      PH_SYNC:   h_last = H_SYNC_LAST;
      default:   h_last = H_BACK_LAST;
    endcase
    case (v_state)
      PH_ACTIVE: v_last = V_ACTIVE_LAST;
      PH_FRONT:  v_last = V_FRONT_LAST;
      PH_SYNC:   v_last = V_SYNC_LAST;
      default:   v_last = V_BACK_LAST;
    endcase
  end

  // Next-state logic; an out-of-range counter falls back to the reset position.
  always_comb begin
    h_state_nxt  = h_state;
    h_cnt_nxt    = h_cnt;
    v_state_nxt  = v_state;
    v_cnt_nxt    = v_cnt;
    end_of_line  = 1'b0;
    end_of_frame = 1'b0;
    if ((h_cnt > h_last) || (v_cnt > v_last)) begin
      h_state_nxt = PH_BACK;
      h_cnt_nxt   = H_BACK_LAST;
      v_state_nxt = PH_BACK;
      v_cnt_nxt   = V_BACK_LAST;
    end else if (enable) begin
      if (h_cnt == h_last) begin
        h_state_nxt = next_phase(h_state);
        h_cnt_nxt   = '0;
        if (h_state == PH_BACK) begin
          end_of_line = 1'b1;
          if (v_cnt == v_last) begin
            v_state_nxt  = next_phase(v_state);
            v_cnt_nxt    = '0;
            end_of_frame = (v_state == PH_BACK);
          end else begin
            v_cnt_nxt = v_cnt + CW'(1);
          end
        end
      end else begin
        h_cnt_nxt = h_cnt + CW'(1);
      end
    end
  end

  // State registers and outputs, all describing the position being entered.
  always_ff @(posedge control_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_state        <= PH_BACK;
      h_cnt          <= H_BACK_LAST;
      v_state        <= PH_BACK;
      v_cnt          <= V_BACK_LAST;
      h_sync         <= SYNC_OFF;
      v_sync         <= SYNC_OFF;
      display_enable <= 1'b0;
      pixel_x        <= '0;
      pixel_y        <= '0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      h_state        <= h_state_nxt;
      h_cnt          <= h_cnt_nxt;
      v_state        <= v_state_nxt;
      v_cnt          <= v_cnt_nxt;
      h_sync         <= (h_state_nxt == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      v_sync         <= (v_state_nxt == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      display_enable <= (h_state_nxt == PH_ACTIVE) && (v_state_nxt == PH_ACTIVE);
      pixel_x        <= (h_state_nxt == PH_ACTIVE) ? h_cnt_nxt : '0;
      pixel_y        <= (v_state_nxt == PH_ACTIVE) ? v_cnt_nxt : '0;
      line_start     <= end_of_line;
      frame_start    <= end_of_frame;
    end
  end

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Bench for vga_timing_sequencer: three instances (default timing, small timing with
// both sync polarities) checked every cycle against a raster-position model plus literals.
module tb_vga_timing_sequencer;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] px;
    logic [10:0] py;
    logic        ls;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic chk_on = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic        d0_hs, d0_vs, d0_de, d0_ls, d0_fs;
  logic [10:0] d0_px, d0_py;
  logic        d1_hs, d1_vs, d1_de, d1_ls, d1_fs;
  logic [10:0] d1_px, d1_py;
  logic        d2_hs, d2_vs, d2_de, d2_ls, d2_fs;
  logic [10:0] d2_px, d2_py;

  always #5 clk = ~clk;

  vga_timing_sequencer u_d0 (
    .control_clock(clk), .reset_n(reset_n), .enable(enable),
    .h_sync(d0_hs), .v_sync(d0_vs), .display_enable(d0_de),
    .pixel_x(d0_px), .pixel_y(d0_py), .line_start(d0_ls), .frame_start(d0_fs)
  );

  vga_timing_sequencer #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_LOW(1'b1), .COUNTER_SIZE(11)
  ) u_d1 (
    .control_clock(clk), .reset_n(reset_n), .enable(enable),
    .h_sync(d1_hs), .v_sync(d1_vs), .display_enable(d1_de),
    .pixel_x(d1_px), .pixel_y(d1_py), .line_start(d1_ls), .frame_start(d1_fs)
  );

  vga_timing_sequencer #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_LOW(1'b0), .COUNTER_SIZE(11)
  ) u_d2 (
    .control_clock(clk), .reset_n(reset_n), .enable(enable),
    .h_sync(d2_hs), .v_sync(d2_vs), .display_enable(d2_de),
    .pixel_x(d2_px), .pixel_y(d2_py), .line_start(d2_ls), .frame_start(d2_fs)
  );

  // Model state: enables seen since reset, linear raster position, last-edge enable.
  logic   started;
  logic   pulse;
  longint k_def;
  longint k_sml;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started <= 1'b0;
      pulse   <= 1'b0;
      k_def   <= 0;
      k_sml   <= 0;
    end else begin
      pulse <= enable;
      if (enable) begin
        started <= 1'b1;
        k_def   <= started ? (k_def + 1) % (1344 * 806) : 0;
        k_sml   <= started ? (k_sml + 1) % (8 * 6) : 0;
      end
    end
  end

  function automatic int phase_of(int pos, int a, int f, int s);
    if (pos < a)         return 0;
    if (pos < a + f)     return 1;
    if (pos < a + f + s) return 2;
    return 3;
  endfunction

  function automatic obs_t model(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb,
                                 bit pol_low, bit st, longint k, bit pl);
    obs_t e;
    int   ht, hx, vy, hp, vp;
    logic off;
    off = pol_low;
    e   = '0;
    e.hs = off;
    e.vs = off;
    if (st) begin
      ht = ha + hf + hs + hb;
      hx = int'(k % longint'(ht));
      vy = int'(k / longint'(ht));
      hp = phase_of(hx, ha, hf, hs);
      vp = phase_of(vy, va, vf, vs);
      e.hs = (hp == 2) ? !off : off;
      e.vs = (vp == 2) ? !off : off;
      e.de = (hp == 0) && (vp == 0);
      e.px = (hp == 0) ? 11'(hx) : 11'd0;
      e.py = (vp == 0) ? 11'(vy) : 11'd0;
      e.ls = pl && (hx == 0);
      e.fs = pl && (k == 0);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".h_sync"}, 32'(a.hs), 32'(e.hs));
    chk({tag, ".v_sync"}, 32'(a.vs), 32'(e.vs));
    chk({tag, ".display_enable"}, 32'(a.de), 32'(e.de));
    chk({tag, ".pixel_x"}, 32'(a.px), 32'(e.px));
    chk({tag, ".pixel_y"}, 32'(a.py), 32'(e.py));
    chk({tag, ".line_start"}, 32'(a.ls), 32'(e.ls));
    chk({tag, ".frame_start"}, 32'(a.fs), 32'(e.fs));
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("d0", {d0_hs, d0_vs, d0_de, d0_px, d0_py, d0_ls, d0_fs},
          model(1024, 24, 136, 160, 768, 3, 6, 29, 1'b1, started, k_def, pulse));
      cmp("d1", {d1_hs, d1_vs, d1_de, d1_px, d1_py, d1_ls, d1_fs},
          model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, started, k_sml, pulse));
      cmp("d2", {d2_hs, d2_vs, d2_de, d2_px, d2_py, d2_ls, d2_fs},
          model(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, started, k_sml, pulse));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic hs_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int   px_tab [8] = '{0, 1, 2, 3, 0, 0, 0, 0};

  initial begin
    reset_n = 1'b1;
    enable  = 1'b0;
    #1 reset_n = 1'b0;
    chk_on = 1'b1;
    step(3);
    chk("rst.d0.h_sync", 32'(d0_hs), 32'd1);
    chk("rst.d2.h_sync", 32'(d2_hs), 32'd0);
    chk("rst.d0.display_enable", 32'(d0_de), 32'd0);
    chk("rst.d0.frame_start", 32'(d0_fs), 32'd0);

    // First enable after release enters (0,0) with both strobes.
    reset_n = 1'b1;
    enable  = 1'b1;
    step(1);
    chk("first.d0.frame_start", 32'(d0_fs), 32'd1);
    chk("first.d0.line_start", 32'(d0_ls), 32'd1);
    chk("first.d0.display_enable", 32'(d0_de), 32'd1);
    chk("first.d0.pixel_x", 32'(d0_px), 32'd0);
    chk("first.d0.pixel_y", 32'(d0_py), 32'd0);
    chk("first.d1.frame_start", 32'(d1_fs), 32'd1);

    // Default horizontal timing: sync low from 1048 to 1183 clocks after line_start.
    step(1047);
    chk("hpos1047.d0.h_sync", 32'(d0_hs), 32'd1);
    chk("hpos1047.d0.display_enable", 32'(d0_de), 32'd0);
    step(1);
    chk("hpos1048.d0.h_sync", 32'(d0_hs), 32'd0);
    step(135);
    chk("hpos1183.d0.h_sync", 32'(d0_hs), 32'd0);
    step(1);
    chk("hpos1184.d0.h_sync", 32'(d0_hs), 32'd1);
    step(160);
    chk("line1.d0.line_start", 32'(d0_ls), 32'd1);
    chk("line1.d0.pixel_y", 32'(d0_py), 32'd1);
    chk("line1.d0.frame_start", 32'(d0_fs), 32'd0);

    // Enable toggling every clock.
    repeat (200) begin
      enable = ~enable;
      step(1);
    end

    // Small timing: per-clock horizontal sequence, vertical sync line, frame wrap.
    reset_n = 1'b0;
    enable  = 1'b0;
    step(2);
    reset_n = 1'b1;
    enable  = 1'b1;
    step(1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step(1);
      chk("seq.d1.h_sync", 32'(d1_hs), 32'(hs_tab[i]));
      chk("seq.d1.pixel_x", 32'(d1_px), 32'(px_tab[i]));
      chk("seq.d2.h_sync", 32'(d2_hs), 32'(!hs_tab[i]));
    end
    step(25);
    chk("vsync.d1.v_sync", 32'(d1_vs), 32'd0);
    chk("vsync.d2.v_sync", 32'(d2_vs), 32'd1);
    chk("vsync.d1.display_enable", 32'(d1_de), 32'd0);
    step(16);
    chk("wrap.d1.frame_start", 32'(d1_fs), 32'd1);
    chk("wrap.d2.frame_start", 32'(d2_fs), 32'd1);
    chk("wrap.d1.display_enable", 32'(d1_de), 32'd1);

    // Asynchronous reset in the middle of horizontal sync.
    step(5);
    chk("presync.d1.h_sync", 32'(d1_hs), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("async.d1.h_sync", 32'(d1_hs), 32'd1);
    chk("async.d2.h_sync", 32'(d2_hs), 32'd0);
    chk("async.d0.display_enable", 32'(d0_de), 32'd0);
    chk("async.d1.line_start", 32'(d1_ls), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("rerun.d0.frame_start", 32'(d0_fs), 32'd1);
    chk("rerun.d1.frame_start", 32'(d1_fs), 32'd1);
    chk("rerun.d2.frame_start", 32'(d2_fs), 32'd1);
    step(20);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
